alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Controller between the serial instruction loader and the ALU datapath. Accepts a completed 4-bit opcode and two operands, and decodes the opcode.
- Issues the operation to a fixed-latency ALU, captures result and flags, then reports completion.
- Holds one pending instruction so the front-end may load the next op while the current one is in flight. Flags overrun and illegal opcodes.

Parameters:
- WIDTH, 8: operand/result width in bits.
- ALU_LATENCY, 2: cycles from the alu_start cycle to alu_result/alu_flags valid; legal range is 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_all_n  input  1  asynchronous, active-low reset; clears all state and outputs
- reset_instr  input  1  synchronous, active-high abort of current and pending work
- instr_valid  input  1  one-cycle pulse: instruction/operands valid this cycle
- instruction  input  4  opcode
- operand_a_in  input  WIDTH  operand A, sampled with instr_valid
- operand_b_in  input  WIDTH  operand B, sampled with instr_valid
- alu_result  input  WIDTH  ALU result
- alu_flags  input  4  ALU flags {neg, ovf, carry, zero}
- alu_op  output  4  opcode to ALU
- alu_a  output  WIDTH  operand A to ALU
- alu_b  output  WIDTH  operand B to ALU
- alu_start  output  1  one-cycle issue strobe
- result  output  WIDTH  last captured result
- flags  output  4  last captured flags
- result_valid  output  1  one-cycle pulse: result/flags updated
- illegal_op  output  1  one-cycle pulse: opcode rejected
- overrun  output  1  sticky: instruction dropped
- busy  output  1  state != IDLE or pending slot full

Behaviour:
- Reset (reset_all_n low, async): state IDLE; every output and internal register = 0.
- Legal opcodes: 4'h0..4'hB. Opcodes 4'hC..4'hF are illegal.
- States are IDLE, ISSUE, WAIT, CAPTURE, DONE and ERROR. An instruction is "accepted" when its opcode and operands are latched into the active registers (op/a/b).
- IDLE, instr_valid=1:
  - Latch op/a/b.
  - Next state is ISSUE if the opcode is legal, ERROR otherwise.
- ISSUE:
  - alu_start=1 for exactly this cycle.
  - Load the latency counter with ALU_LATENCY-1.
  - Next state is WAIT, or CAPTURE if ALU_LATENCY=1.
- WAIT: decrement the counter; go to CAPTURE when the counter reaches 0.
- CAPTURE:
  - This is cycle T+ALU_LATENCY, where T is the ISSUE cycle.
  - Register alu_result into result and alu_flags into flags at the end of this cycle.
  - Next state is DONE.
- DONE: result_valid=1 for this cycle only.
- ERROR:
  - illegal_op=1 for this cycle only.
  - No alu_start is issued; result and flags are unchanged.
- Exit from DONE and ERROR:
  - If the pending slot is full, move pending into the active registers, clear the slot, and decode it (ISSUE or ERROR).
  - Otherwise return to IDLE.
- Latency: instr_valid in cycle 0 gives result_valid in cycle ALU_LATENCY+2 (cycle 4 at the default). Back-to-back throughput is one op per ALU_LATENCY+2 cycles.
- alu_op, alu_a and alu_b are driven from the active registers and stay stable from ISSUE through CAPTURE.
- instr_valid while state != IDLE:
  - If the pending slot is empty, store opcode and operands there.
  - If the slot is full, drop the instruction and set overrun.
- Simultaneous events in DONE/ERROR, pending full, instr_valid=1: the slot is drained and refilled with the new instruction on the same edge. No overrun.
- overrun: sticky; cleared only by reset_instr or reset_all_n.
- reset_instr (synchronous; priority over all other inputs except reset_all_n):
  - State goes to IDLE; pending slot, counter and overrun are cleared.
  - An in-flight op is aborted: no result_valid, result/flags unchanged, alu_start not asserted in that cycle.
  - instr_valid in the same cycle is ignored.
- No arithmetic on data; width follows WIDTH. The counter is 4 bits.

Test Plan:
- Single op: instruction=4'h1, a=8'h05, b=8'h03, ALU model returns 8'h08, flags 4'h0 at latency 2 -> alu_start in cycle 1; result_valid in cycle 4 with result=8'h08, flags=4'h0; busy low in cycle 5.
- Back-to-back: second instr_valid (4'h2, a=8'h10, b=8'h01) in cycle 2 -> stored pending; its ISSUE in cycle 5, result_valid in cycle 8 with its result; overrun=0.
- Overrun: three instr_valid pulses in cycles 0, 1, 2 -> third dropped, overrun=1 and held; only two result_valid pulses; reset_instr clears overrun.
- Illegal opcode: instruction=4'hE -> illegal_op pulse in cycle 1, no alu_start, result unchanged. Illegal opcode in pending behind a legal op -> illegal_op in the cycle after DONE.
- Abort: reset_instr in the WAIT cycle with pending full -> state IDLE next cycle, no result_valid, busy=0, pending lost; the next instr_valid runs normally.
- Async reset: reset_all_n low mid-CAPTURE -> all outputs 0 immediately. ALU_LATENCY=1 build -> result_valid at cycle 3.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_sequencer_if
//   Bundles the instruction-loader side, the ALU side and the status outputs
//   of the ALU sequencer.
//   Signals:
//     instr_valid/instruction/operand_a_in/operand_b_in  loader -> sequencer
//     alu_result/alu_flags                               ALU -> sequencer
//     alu_op/alu_a/alu_b/alu_start                       sequencer -> ALU
//     result/flags/result_valid/illegal_op/overrun/busy  sequencer status
//   Modports:
//     slave  : the sequencer itself
//     master : the environment (loader + ALU) driving the sequencer
// -----------------------------------------------------------------------------
interface alu_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             instr_valid;
  logic [3:0]       instruction;
  logic [WIDTH-1:0] operand_a_in;
  logic [WIDTH-1:0] operand_b_in;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_start;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             result_valid;
  logic             illegal_op;
  logic             overrun;
  logic             busy;

  modport slave (
    input  instr_valid, instruction, operand_a_in, operand_b_in,
    input  alu_result, alu_flags,
    output alu_op, alu_a, alu_b, alu_start,
    output result, flags, result_valid, illegal_op, overrun, busy
  );

  modport master (
    output instr_valid, instruction, operand_a_in, operand_b_in,
    output alu_result, alu_flags,
    input  alu_op, alu_a, alu_b, alu_start,
    input  result, flags, result_valid, illegal_op, overrun, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Accepts an opcode plus two operands, decodes it, issues it to a
//   fixed-latency ALU, captures the ALU result/flags and pulses completion.
//   One pending slot lets the loader queue the next instruction while the
//   current one is in flight; a further instruction is dropped and flagged
//   with the sticky overrun bit. Opcodes 4'hC..4'hF are rejected.
//   Ports:
//     clk          rising-edge clock
//     reset_all_n  asynchronous active-low reset, clears everything
//     reset_instr  synchronous abort of active and pending work
//     bus          alu_sequencer_if.slave (loader, ALU and status signals)
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int WIDTH       = 8,
  parameter int ALU_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_all_n,
  input  logic              reset_instr,
  alu_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LATENCY - 1);

  state_t           state_reg, state_next;
  logic [3:0]       op_reg, op_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             pend_full_reg, pend_full_next;
  logic [3:0]       pend_op_reg, pend_op_next;
  logic [WIDTH-1:0] pend_a_reg, pend_a_next;
  logic [WIDTH-1:0] pend_b_reg, pend_b_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [3:0]       flags_reg, flags_next;
  logic             overrun_reg, overrun_next;
  logic             drain;

  function automatic logic is_legal(input logic [3:0] op);
    return op < 4'hC;
  endfunction

  always_ff @(posedge clk or negedge reset_all_n) begin
    if (!reset_all_n) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      pend_full_reg <= 1'b0;
      pend_op_reg   <= '0;
      pend_a_reg    <= '0;
      pend_b_reg    <= '0;
      cnt_reg       <= '0;
      result_reg    <= '0;
      flags_reg     <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      pend_full_reg <= pend_full_next;
      pend_op_reg   <= pend_op_next;
      pend_a_reg    <= pend_a_next;
      pend_b_reg    <= pend_b_next;
      cnt_reg       <= cnt_next;
      result_reg    <= result_next;
      flags_reg     <= flags_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    pend_full_next = pend_full_reg;
    pend_op_next   = pend_op_reg;
    pend_a_next    = pend_a_reg;
    pend_b_next    = pend_b_reg;
    cnt_next       = cnt_reg;
    result_next    = result_reg;
    flags_next     = flags_reg;
    overrun_next   = overrun_reg;
    drain          = 1'b0;

    if (reset_instr) begin
      // Abort wins over everything, including a same-cycle instr_valid.
      state_next     = IDLE;
      pend_full_next = 1'b0;
      cnt_next       = '0;
      overrun_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A slot filled during the final DONE/ERROR cycle is drained here
          // so it can never be stranded behind an idle FSM.
          if (pend_full_reg) begin
            drain = 1'b1;
          end else if (bus.instr_valid) begin
            op_next    = bus.instruction;
            a_next     = bus.operand_a_in;
            b_next     = bus.operand_b_in;
            state_next = is_legal(bus.instruction) ? ISSUE : ERROR;
          end
        end
        ISSUE: begin
          cnt_next   = LAT_M1;
          state_next = (ALU_LATENCY == 1) ? CAPTURE : WAIT;
        end
        WAIT: begin
          cnt_next = cnt_reg - 4'd1;
          // The counter reaches 0 on this edge, so CAPTURE lands on T+latency.
          if (cnt_reg == 4'd1) begin
            state_next = CAPTURE;
          end
        end
        CAPTURE: begin
          result_next = bus.alu_result;
          flags_next  = bus.alu_flags;
          state_next  = DONE;
        end
        DONE, ERROR: begin
          if (pend_full_reg) begin
            drain = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase

      if (drain) begin
        op_next        = pend_op_reg;
        a_next         = pend_a_reg;
        b_next         = pend_b_reg;
        pend_full_next = 1'b0;
        state_next     = is_legal(pend_op_reg) ? ISSUE : ERROR;
      end

      // Anything not taken straight into the active registers goes to the
      // pending slot; a slot being drained this edge can be refilled.
      if (bus.instr_valid && !(state_reg == IDLE && !pend_full_reg)) begin
        if (!pend_full_reg || drain) begin
          pend_op_next   = bus.instruction;
          pend_a_next    = bus.operand_a_in;
          pend_b_next    = bus.operand_b_in;
          pend_full_next = 1'b1;
        end else begin
          overrun_next = 1'b1;
        end
      end
    end
  end

  // Strobes are masked by reset_instr so an aborted op leaves no trace.
  assign bus.alu_start    = (state_reg == ISSUE) && !reset_instr;
  assign bus.result_valid = (state_reg == DONE) && !reset_instr;
  assign bus.illegal_op   = (state_reg == ERROR) && !reset_instr;
  assign bus.alu_op       = op_reg;
  assign bus.alu_a        = a_reg;
  assign bus.alu_b        = b_reg;
  assign bus.result       = result_reg;
  assign bus.flags        = flags_reg;
  assign bus.overrun      = overrun_reg;
  assign bus.busy         = (state_reg != IDLE) || pend_full_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//   Directed bench for alu_sequencer. A small ALU model (result = a + b,
//   flags {neg, ovf, carry, zero}) answers alu_start after the configured
//   latency and drives junk otherwise. Expected issues and completions are
//   queued when an instruction is driven and popped when the DUT produces
//   alu_start / result_valid / illegal_op. A second instance is built with
//   ALU_LATENCY = 1.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  logic clk;
  logic reset_all_n;
  logic reset_instr;
  logic l1_reset_instr;

  alu_sequencer_if #(.WIDTH(8)) dut_if ();
  alu_sequencer_if #(.WIDTH(8)) l1_if ();

  alu_sequencer #(.WIDTH(8), .ALU_LATENCY(2)) dut (
    .clk         (clk),
    .reset_all_n (reset_all_n),
    .reset_instr (reset_instr),
    .bus         (dut_if)
  );

  alu_sequencer #(.WIDTH(8), .ALU_LATENCY(1)) dut_l1 (
    .clk         (clk),
    .reset_all_n (reset_all_n),
    .reset_instr (l1_reset_instr),
    .bus         (l1_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU model ----------------
  function automatic logic [7:0] alu_res(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  function automatic logic [3:0] alu_flg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {s[7], (a[7] == b[7]) && (s[7] != a[7]), s[8], s[7:0] == 8'h00};
  endfunction

  logic [7:0] s1_res, s2_res, l1_res;
  logic [3:0] s1_flg, s2_flg, l1_flg;

  always @(posedge clk) begin
    if (dut_if.alu_start) begin
      s1_res <= alu_res(dut_if.alu_a, dut_if.alu_b);
      s1_flg <= alu_flg(dut_if.alu_a, dut_if.alu_b);
    end else begin
      s1_res <= 8'hA5;
      s1_flg <= 4'hA;
    end
    s2_res <= s1_res;
    s2_flg <= s1_flg;
    if (l1_if.alu_start) begin
      l1_res <= alu_res(l1_if.alu_a, l1_if.alu_b);
      l1_flg <= alu_flg(l1_if.alu_a, l1_if.alu_b);
    end else begin
      l1_res <= 8'h5A;
      l1_flg <= 4'h5;
    end
  end

  assign dut_if.alu_result = s2_res;
  assign dut_if.alu_flags  = s2_flg;
  assign l1_if.alu_result  = l1_res;
  assign l1_if.alu_flags   = l1_flg;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         cyc;
  } iss_t;

  typedef struct {
    logic       illegal;
    logic [7:0] res;
    logic [3:0] flg;
    int         cyc;
  } exp_t;

  iss_t iq[$];
  exp_t sbq[$];

  int         checks;
  int         failures;
  int         cyc;
  logic [7:0] last_res;
  logic [3:0] last_flg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge and match DUT events.
  task automatic tick();
    iss_t ie;
    exp_t ee;
    @(posedge clk);
    #1;
    cyc++;
    if (iq.size() != 0 && iq[0].cyc < cyc) begin
      chk("missed_alu_start", cyc, iq[0].cyc);
      void'(iq.pop_front());
    end
    if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
      chk("missed_completion", cyc, sbq[0].cyc);
      void'(sbq.pop_front());
    end
    if (dut_if.alu_start) begin
      if (iq.size() == 0) begin
        chk("unexpected_alu_start", dut_if.alu_start, 1'b0);
      end else begin
        ie = iq.pop_front();
        chk("issue_cycle", cyc, ie.cyc);
        chk("alu_op", dut_if.alu_op, ie.op);
        chk("alu_a", dut_if.alu_a, ie.a);
        chk("alu_b", dut_if.alu_b, ie.b);
      end
    end
    if (dut_if.result_valid || dut_if.illegal_op) begin
      if (sbq.size() == 0) begin
        chk("unexpected_completion", {dut_if.result_valid, dut_if.illegal_op}, 2'b00);
      end else begin
        ee = sbq.pop_front();
        chk("completion_cycle", cyc, ee.cyc);
        chk("completion_kind", {dut_if.result_valid, dut_if.illegal_op}, ee.illegal ? 2'b01 : 2'b10);
        if (ee.illegal) begin
          chk("result_kept_on_illegal", dut_if.result, last_res);
          chk("flags_kept_on_illegal", dut_if.flags, last_flg);
          $display("txn cyc=%0d illegal_op", cyc);
        end else begin
          chk("result", dut_if.result, ee.res);
          chk("flags", dut_if.flags, ee.flg);
          last_res = ee.res;
          last_flg = ee.flg;
          $display("txn cyc=%0d result=%02h flags=%01h", cyc, dut_if.result, dut_if.flags);
        end
      end
    end
  endtask

  // track: 0 = expect nothing, 1 = expect issue only, 2 = expect issue + completion
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input int track, input int iss_d, input int done_d);
    iss_t ie;
    exp_t ee;
    dut_if.instr_valid  = 1'b1;
    dut_if.instruction  = op;
    dut_if.operand_a_in = a;
    dut_if.operand_b_in = b;
    if (track != 0) begin
      if (op < 4'hC) begin
        ie.op = op; ie.a = a; ie.b = b; ie.cyc = cyc + iss_d;
        iq.push_back(ie);
        if (track == 2) begin
          ee.illegal = 1'b0; ee.res = alu_res(a, b); ee.flg = alu_flg(a, b);
          ee.cyc = cyc + done_d;
          sbq.push_back(ee);
        end
      end else begin
        ee.illegal = 1'b1; ee.res = 8'h00; ee.flg = 4'h0; ee.cyc = cyc + done_d;
        sbq.push_back(ee);
      end
    end
    tick();
    dut_if.instr_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    last_res = 8'h00;
    last_flg = 4'h0;
    reset_all_n    = 1'b0;
    reset_instr    = 1'b0;
    l1_reset_instr = 1'b0;
    dut_if.instr_valid  = 1'b0;
    dut_if.instruction  = 4'h0;
    dut_if.operand_a_in = 8'h00;
    dut_if.operand_b_in = 8'h00;
    l1_if.instr_valid   = 1'b0;
    l1_if.instruction   = 4'h0;
    l1_if.operand_a_in  = 8'h00;
    l1_if.operand_b_in  = 8'h00;

    // Reset state
    tick();
    tick();
    chk("reset_busy", dut_if.busy, 1'b0);
    chk("reset_result", dut_if.result, 8'h00);
    chk("reset_flags", dut_if.flags, 4'h0);
    chk("reset_overrun", dut_if.overrun, 1'b0);
    chk("reset_alu_op", dut_if.alu_op, 4'h0);
    reset_all_n = 1'b1;
    tick();

    // Single op: issue at +1, result at +4, idle at +5
    send(4'h1, 8'h05, 8'h03, 2, 1, 4);
    chk("single_busy_c1", dut_if.busy, 1'b1);
    repeat (4) tick();
    chk("single_busy_c5", dut_if.busy, 1'b0);
    chk("single_result_held", dut_if.result, 8'h08);

    // Back-to-back: second op lands in the pending slot
    send(4'h1, 8'h05, 8'h03, 2, 1, 4);
    tick();
    send(4'h2, 8'h10, 8'h01, 2, 3, 6);
    repeat (7) tick();
    chk("b2b_overrun", dut_if.overrun, 1'b0);
    chk("b2b_busy", dut_if.busy, 1'b0);

    // Overrun: third instruction dropped, sticky until reset_instr
    send(4'h3, 8'h20, 8'h22, 2, 1, 4);
    send(4'h4, 8'h7F, 8'h01, 2, 4, 7);
    send(4'h5, 8'h99, 8'h99, 0, 0, 0);
    chk("overrun_set", dut_if.overrun, 1'b1);
    repeat (7) tick();
    chk("overrun_sticky", dut_if.overrun, 1'b1);
    chk("overrun_idle", dut_if.busy, 1'b0);
    reset_instr = 1'b1;
    tick();
    reset_instr = 1'b0;
    chk("overrun_cleared", dut_if.overrun, 1'b0);

    // Illegal opcode from IDLE
    send(4'hE, 8'h33, 8'h44, 2, 0, 1);
    tick();
    chk("illegal_idle", dut_if.busy, 1'b0);

    // Carry/zero flags, then an illegal opcode pending behind it
    send(4'h5, 8'hFF, 8'h01, 2, 1, 4);
    send(4'hF, 8'h00, 8'h00, 2, 0, 4);
    repeat (5) tick();
    chk("illegal_pend_idle", dut_if.busy, 1'b0);

    // Abort in WAIT with the pending slot full
    send(4'h6, 8'h01, 8'h02, 1, 1, 0);
    send(4'h7, 8'h03, 8'h04, 0, 0, 0);
    reset_instr = 1'b1;
    tick();
    reset_instr = 1'b0;
    chk("abort_busy", dut_if.busy, 1'b0);
    repeat (4) tick();
    chk("abort_result_kept", dut_if.result, last_res);

    // instr_valid together with reset_instr is ignored
    reset_instr = 1'b1;
    send(4'h1, 8'h44, 8'h44, 0, 0, 0);
    reset_instr = 1'b0;
    chk("abort_ignores_instr", dut_if.busy, 1'b0);
    repeat (3) tick();

    // Normal op after the abort
    send(4'h8, 8'h0A, 8'h0B, 2, 1, 4);
    repeat (4) tick();

    // Async reset in the middle of CAPTURE (pending full, overrun set)
    send(4'h9, 8'h12, 8'h34, 1, 1, 0);
    send(4'hA, 8'h56, 8'h78, 0, 0, 0);
    send(4'hB, 8'h9A, 8'hBC, 0, 0, 0);
    chk("pre_reset_overrun", dut_if.overrun, 1'b1);
    #2;
    reset_all_n = 1'b0;
    #1;
    chk("async_busy", dut_if.busy, 1'b0);
    chk("async_result", dut_if.result, 8'h00);
    chk("async_flags", dut_if.flags, 4'h0);
    chk("async_overrun", dut_if.overrun, 1'b0);
    chk("async_alu_a", dut_if.alu_a, 8'h00);
    chk("async_alu_op", dut_if.alu_op, 4'h0);
    last_res = 8'h00;
    last_flg = 4'h0;
    tick();
    tick();
    reset_all_n = 1'b1;
    tick();

    // ALU_LATENCY = 1 instance: result_valid at cycle 3
    l1_if.instr_valid  = 1'b1;
    l1_if.instruction  = 4'h1;
    l1_if.operand_a_in = 8'h05;
    l1_if.operand_b_in = 8'h03;
    tick();
    l1_if.instr_valid = 1'b0;
    chk("l1_start_c1", l1_if.alu_start, 1'b1);
    tick();
    chk("l1_no_valid_c2", l1_if.result_valid, 1'b0);
    tick();
    chk("l1_valid_c3", l1_if.result_valid, 1'b1);
    chk("l1_result_c3", l1_if.result, 8'h08);
    $display("txn l1 cyc=%0d result=%02h flags=%01h", cyc, l1_if.result, l1_if.flags);
    tick();
    chk("l1_idle_c4", l1_if.busy, 1'b0);

    tick();
    chk("issue_queue_empty", iq.size(), 0);
    chk("completion_queue_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
